// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier.
// Accepts one operand pair and a signed/unsigned mode, and retires one Booth
// step per clock. The product is presented with a valid/ready handshake.
// Both operands are widened by one bit at acceptance. This lets a single
// signed Booth datapath cover both modes: the unsigned operands are
// zero-extended, and the signed operands are sign-extended.
module booth_mult_seq #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in1,
    input  logic [WIDTH-1:0]   in2,
    input  logic               is_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH:0]   out,
    output logic               busy
);

    // Operand width after extension, accumulator width, step-counter width.
    localparam int OW = WIDTH + 1;
    localparam int AW = WIDTH + 2;
    localparam int CW = $clog2(WIDTH + 1) + 1;

    // The step index of the final Booth step. WIDTH+1 steps are numbered 0..WIDTH.
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t          state;
    logic [AW-1:0]   acc;       // Booth accumulator A
    logic [OW-1:0]   mplier;    // multiplier / low product half Q
    logic            q_m1;      // q(-1)
    logic [OW-1:0]   mcand;     // extended multiplicand M
    logic [CW-1:0]   step;      // Booth steps already performed

    // Widened operands presented at the input, and the datapath of the next Booth step.
    logic [OW-1:0]   in1_ext;
    logic [OW-1:0]   in2_ext;
    logic [AW-1:0]   mcand_ext;
    logic [AW-1:0]   step_sum;
    logic [AW-1:0]   next_acc;
    logic [OW-1:0]   next_mplier;

    // Widen the incoming operands according to the requested mode.
    always_comb begin
        // NOTE: every signal written here gets a value on every path, so no latch is inferred.
        in1_ext = is_signed ? {in1[WIDTH-1], in1} : {1'b0, in1};
        in2_ext = is_signed ? {in2[WIDTH-1], in2} : {1'b0, in2};
    end

    // Perform one Booth step: a conditional add or subtract, then an arithmetic right shift.
    always_comb begin
        mcand_ext = {mcand[OW-1], mcand};
        step_sum  = acc;
        case ({mplier[0], q_m1})
            2'b01:   step_sum = acc + mcand_ext;
            2'b10:   step_sum = acc - mcand_ext;
            default: step_sum = acc;
        endcase
        next_acc    = {step_sum[AW-1], step_sum[AW-1:1]};
        next_mplier = {step_sum[0], mplier[OW-1:1]};
    end

    // Control FSM and datapath registers. All outputs are registered.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments, so every register samples pre-edge values.
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            mplier    <= '0;
            q_m1      <= 1'b0;
            mcand     <= '0;
            step      <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand    <= in1_ext;
                        mplier   <= in2_ext;
                        acc      <= '0;
                        q_m1     <= 1'b0;
                        step     <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    acc    <= next_acc;
                    mplier <= next_mplier;
                    q_m1   <= mplier[0];
                    step   <= step + CW'(1);
                    if (step == LAST_STEP) begin
                        // Only the low 2*WIDTH+1 bits of {A,Q} are significant.
                        out       <= {next_acc[WIDTH-1:0], next_mplier};
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    // Hold the product until it is consumed. The handoff edge cannot accept new operands.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench for booth_mult_seq.
// It uses a WIDTH=4 instance for the directed tests and the exhaustive sweep,
// and a WIDTH=8 instance for random samples.
// Expected products are pushed to a scoreboard queue at acceptance and popped when out_valid is seen.
module tb_booth_mult_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // WIDTH=4 instance
    logic       in_valid4 = 1'b0, in_ready4, sgn4 = 1'b0;
    logic       out_valid4, out_ready4 = 1'b0, busy4;
    logic [3:0] in1_4 = '0, in2_4 = '0;
    logic [8:0] out4;

    // WIDTH=8 instance
    logic        in_valid8 = 1'b0, in_ready8, sgn8 = 1'b0;
    logic        out_valid8, out_ready8 = 1'b0, busy8;
    logic [7:0]  in1_8 = '0, in2_8 = '0;
    logic [16:0] out8;

    logic [8:0]  sb4[$];
    logic [16:0] sb8[$];

    booth_mult_seq #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .in1(in1_4), .in2(in2_4), .is_signed(sgn4), .out_valid(out_valid4),
        .out_ready(out_ready4), .out(out4), .busy(busy4)
    );

    booth_mult_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .in1(in1_8), .in2(in2_8), .is_signed(sgn8), .out_valid(out_valid8),
        .out_ready(out_ready8), .out(out8), .busy(busy8)
    );

    // Reference models: extend the operands as the mode requires and multiply at full precision.
    function automatic logic [8:0] ref4(input logic [3:0] a, input logic [3:0] b, input logic s);
        longint x, y, p;
        x = s ? {{60{a[3]}}, a} : {60'd0, a};
        y = s ? {{60{b[3]}}, b} : {60'd0, b};
        p = x * y;
        return p[8:0];
    endfunction

    function automatic logic [16:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic s);
        longint x, y, p;
        x = s ? {{56{a[7]}}, a} : {56'd0, a};
        y = s ? {{56{b[7]}}, b} : {56'd0, b};
        p = x * y;
        return p[16:0];
    endfunction

    // Run one WIDTH=4 multiply. The operands are scrambled while the multiply is in flight.
    // Optionally stall the consumer, then consume the product and check the handoff.
    task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic s,
                        input logic [8:0] expv, input int stall, input bit hold_ready);
        int         edges;
        bit         seen;
        logic [8:0] exp_pop;
        @(negedge clk);
        in1_4 = a; in2_4 = b; sgn4 = s; in_valid4 = 1'b1; out_ready4 = hold_ready;
        checks++;
        if (in_ready4 !== 1'b1) begin
            failures++;
            $display("FAIL in_ready_idle got=%b want=1", in_ready4);
        end
        sb4.push_back(expv);
        @(posedge clk); #1;
        // in_valid is left high with junk operands. CALC must ignore both.
        in1_4 = ~a; in2_4 = a ^ b; sgn4 = ~s;
        checks++;
        if (busy4 !== 1'b1 || in_ready4 !== 1'b0) begin
            failures++;
            $display("FAIL calc_flags busy=%b in_ready=%b want busy=1 in_ready=0", busy4, in_ready4);
        end
        seen = 1'b0;
        edges = 0;
        for (int n = 1; n <= 40 && !seen; n++) begin
            @(posedge clk); #1;
            if (out_valid4 === 1'b1) begin
                seen = 1'b1;
                edges = n;
            end
        end
        in_valid4 = 1'b0;
        checks++;
        if (!seen || edges != 5) begin
            failures++;
            $display("FAIL latency4 got=%0d edges (seen=%b) want=5", edges, seen);
        end
        if (!seen) begin
            rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
            void'(sb4.pop_front());
            return;
        end
        checks++;
        if (sb4.size() == 0) begin
            failures++;
            $display("FAIL sb4_empty got=%h want=queued result", out4);
        end else begin
            exp_pop = sb4.pop_front();
            if (out4 !== exp_pop) begin
                failures++;
                $display("FAIL product4 a=%h b=%h s=%b got=%h want=%h", a, b, s, out4, exp_pop);
            end
        end
        if (!hold_ready) begin
            for (int i = 0; i < stall; i++) begin
                @(posedge clk); #1;
                checks++;
                if (out4 !== expv || out_valid4 !== 1'b1 || in_ready4 !== 1'b0) begin
                    failures++;
                    $display("FAIL stall_hold out=%h ov=%b ir=%b want out=%h ov=1 ir=0",
                             out4, out_valid4, in_ready4, expv);
                end
            end
        end
        out_ready4 = 1'b1;
        @(posedge clk); #1;
        out_ready4 = 1'b0;
        checks++;
        if (out_valid4 !== 1'b0 || in_ready4 !== 1'b1 || out4 !== expv) begin
            failures++;
            $display("FAIL handoff ov=%b ir=%b out=%h want ov=0 ir=1 out=%h",
                     out_valid4, in_ready4, out4, expv);
        end
    endtask

    // Run one WIDTH=8 multiply with latency and value checks.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic s, input int stall);
        int          edges;
        bit          seen;
        logic [16:0] exp_pop;
        @(negedge clk);
        in1_8 = a; in2_8 = b; sgn8 = s; in_valid8 = 1'b1; out_ready8 = 1'b0;
        sb8.push_back(ref8(a, b, s));
        @(posedge clk); #1;
        in_valid8 = 1'b0; in1_8 = ~a; in2_8 = ~b;
        seen = 1'b0;
        edges = 0;
        for (int n = 1; n <= 60 && !seen; n++) begin
            @(posedge clk); #1;
            if (out_valid8 === 1'b1) begin
                seen = 1'b1;
                edges = n;
            end
        end
        checks++;
        if (!seen || edges != 9) begin
            failures++;
            $display("FAIL latency8 got=%0d edges (seen=%b) want=9", edges, seen);
        end
        exp_pop = sb8.pop_front();
        checks++;
        if (out8 !== exp_pop) begin
            failures++;
            $display("FAIL product8 a=%h b=%h s=%b got=%h want=%h", a, b, s, out8, exp_pop);
        end
        repeat (stall) @(posedge clk);
        #1 out_ready8 = 1'b1;
        @(posedge clk); #1;
        out_ready8 = 1'b0;
        checks++;
        if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1) begin
            failures++;
            $display("FAIL handoff8 ov=%b ir=%b want ov=0 ir=1", out_valid8, in_ready8);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out4 !== 9'h000 || out_valid4 !== 1'b0 || busy4 !== 1'b0 || in_ready4 !== 1'b1) begin
            failures++;
            $display("FAIL reset_state out=%h ov=%b busy=%b ir=%b want out=000 ov=0 busy=0 ir=1",
                     out4, out_valid4, busy4, in_ready4);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_signed();
        run4(4'b0111, 4'b0011, 1'b1, 9'h015, 0, 1'b1);
    endtask

    task automatic test_sign_combos();
        run4(4'd7,    4'hD, 1'b1, 9'h1EB, 1, 1'b0);
        run4(4'h8,    4'h8, 1'b1, 9'h040, 0, 1'b0);
        run4(4'h8,    4'd7, 1'b1, 9'h1C8, 2, 1'b0);
    endtask

    task automatic test_unsigned();
        run4(4'hF, 4'hF, 1'b0, 9'h0E1, 0, 1'b0);
        run4(4'h8, 4'h0, 1'b0, 9'h000, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        run4(4'd5, 4'd6, 1'b0, 9'h01E, 10, 1'b0);
    endtask

    task automatic test_reset_mid();
        // Leave a non-zero product in out so that the reset clearing it is visible.
        run4(4'd3, 4'd5, 1'b0, 9'h00F, 0, 1'b0);
        @(negedge clk);
        in1_4 = 4'd7; in2_4 = 4'd7; sgn4 = 1'b1; in_valid4 = 1'b1;
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (out4 !== 9'h000 || out_valid4 !== 1'b0 || in_ready4 !== 1'b1 || busy4 !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid out=%h ov=%b ir=%b busy=%b want 000/0/1/0",
                     out4, out_valid4, in_ready4, busy4);
        end
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid4 !== 1'b0 || out4 !== 9'h000) begin
                failures++;
                $display("FAIL no_partial ov=%b out=%h want ov=0 out=000", out_valid4, out4);
            end
        end
        run4(4'd3, 4'd3, 1'b1, 9'h009, 0, 1'b0);
    endtask

    task automatic test_reset_done();
        @(negedge clk);
        in1_4 = 4'd6; in2_4 = 4'd6; sgn4 = 1'b0; in_valid4 = 1'b1; out_ready4 = 1'b0;
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (out_valid4 !== 1'b1 || out4 !== 9'h024) begin
            failures++;
            $display("FAIL done_before_rst ov=%b out=%h want ov=1 out=024", out_valid4, out4);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (out_valid4 !== 1'b0 || out4 !== 9'h000 || in_ready4 !== 1'b1) begin
            failures++;
            $display("FAIL reset_done ov=%b out=%h ir=%b want 0/000/1", out_valid4, out4, in_ready4);
        end
    endtask

    task automatic test_sweep4();
        for (int s = 0; s < 2; s++)
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b++)
                    run4(4'(a), 4'(b), 1'(s), ref4(4'(a), 4'(b), 1'(s)),
                         int'($urandom_range(0, 2)), 1'b0);
    endtask

    task automatic test_width8();
        run8(8'h80, 8'h80, 1'b1, 0);
        run8(8'hFF, 8'hFF, 1'b0, 1);
        run8(8'h7F, 8'h80, 1'b1, 0);
        for (int i = 0; i < 150; i++)
            run8(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    endtask

    initial begin
        test_reset();
        test_signed();
        test_sign_combos();
        test_unsigned();
        test_backpressure();
        test_reset_mid();
        test_reset_done();
        test_sweep4();
        test_width8();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/booth_mult_seq.md
BOOTH_MULT_SEQ -- requirements
Module: booth_mult_seq

Interface
REQ-001 Parameter: WIDTH, default 4, operand width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: in_valid  input  1  operand pair and mode are valid this cycle.
REQ-005 Port: in_ready  output  1  block can accept a new operand pair.
REQ-006 Port: in1  input  WIDTH  multiplicand.
REQ-007 Port: in2  input  WIDTH  multiplier.
REQ-008 Port: is_signed  input  1  1 means in1/in2 are two's complement; 0 means unsigned; sampled with the operands.
REQ-009 Port: out_valid  output  1  out holds a finished product.
REQ-010 Port: out_ready  input  1  consumer accepts out this cycle.
REQ-011 Port: out  output  2*WIDTH+1  product, two's complement.
REQ-012 Port: busy  output  1  high while in CALC.

Function
REQ-013 The FSM SHALL have the states IDLE, CALC and DONE.
REQ-014 In IDLE, in_ready SHALL be 1; out_valid and busy SHALL be 0.
REQ-015 Acceptance SHALL occur on an edge where in_valid&in_ready=1.
  - Latch in1, in2 and is_signed.
  - Extend each operand to WIDTH+1 bits: sign extension if is_signed=1, zero extension if is_signed=0.
  - Clear the accumulator and q(-1), load the step counter with 0, and go to CALC.
REQ-016 In CALC, in_ready SHALL be 0 and busy SHALL be 1; in_valid SHALL be ignored.
REQ-017 Each CALC cycle SHALL perform exactly one radix-2 Booth step on the pair {Q[0], q(-1)}:
  - 01: A = A + M.
  - 10: A = A - M.
  - 00 or 11: no add.
  - Then arithmetic-shift {A, Q, q(-1)} right by one.
REQ-018 The accumulator A SHALL be at least WIDTH+2 bits so that subtracting the most-negative M never overflows.
REQ-019 After exactly WIDTH+1 steps, the FSM SHALL go to DONE; out_valid SHALL first be 1 exactly WIDTH+1 edges after the acceptance edge.
REQ-020 out SHALL equal the low 2*WIDTH+1 bits of {A,Q}; this is the exact product for every signed and unsigned operand pair.
REQ-021 In DONE, out_valid SHALL be 1 and out SHALL be held stable until an edge with out_ready=1; that edge SHALL return the FSM to IDLE.
REQ-022 out_ready SHALL be ignored outside DONE.
REQ-023 A new operand pair SHALL NOT be accepted in the same cycle as the DONE→IDLE handoff, because in_ready is 0 in DONE; the minimum issue interval is WIDTH+3 cycles.
REQ-024 out SHALL retain the last product after leaving DONE until the next result overwrites it.
REQ-025 Operands and is_signed presented while in CALC or DONE SHALL NOT affect the result in flight.

Reset
REQ-026 When rst=1 at a rising edge:
  - FSM goes to IDLE.
  - out=0, out_valid=0, busy=0, step counter=0, accumulator and registers=0.
  - in_ready=1 from the following cycle.
REQ-027 rst SHALL override every other input in any state, including mid-CALC and in DONE with out_ready=0.
REQ-028 No partial result SHALL ever become visible after a reset.

Verification (WIDTH=4 unless stated)
REQ-029 Signed multiply: rst high for 2 cycles, then in1=4'b0111, in2=4'b0011, is_signed=1, in_valid=1, out_ready=1 -> out_valid high 5 edges after acceptance, out=9'h015 (21).
REQ-030 Sign combinations:
  - Signed 7 x -3 -> out=9'h1EB (-21).
  - Signed -8 x -8 -> out=9'h040 (64).
  - Signed -8 x 7 -> out=9'h1C8 (-56).
REQ-031 Unsigned multiply: is_signed=0, 15 x 15 -> out=9'h0E1 (225); is_signed=0, 8 x 0 -> out=9'h000.
REQ-032 Backpressure: out_ready=0 for 10 cycles after out_valid -> out, out_valid=1 and in_ready=0 remain stable; out_ready=1 for one cycle -> next cycle in_ready=1, out_valid=0.
REQ-033 Reset mid-operation: rst pulsed on the 2nd CALC cycle -> next cycle state IDLE, out=0, out_valid=0; a fresh 3 x 3 signed then yields out=9'h009.
REQ-034 Exhaustive and parameter checks:
  - Sweep all 256 operand pairs in both modes for WIDTH=4 with random out_ready stalls; compare against a reference model.
  - Repeat with WIDTH=8 on random samples; check out_valid timing of 9 edges.
